uart_tx_sched: RTL and testbench

- Shares one UART transmitter between N requesters using round-robin arbitration with frame locking.
- A requester that wins keeps the grant until it sends a byte marked last, so multi-byte messages (alarm reports, status dumps) are never interleaved.
- Sits between system clients and the UART transmitter; drives its send/data inputs and watches its ready output.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_arb.sv | 42 ++++
 rtl/uart_tx_sched.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and default timing parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SEND     = 3'd2,
        S_WAITBUSY = 3'd3,
        S_WAITDONE = 3'd4,
        S_RELEASE  = 3'd5,
        S_GAP      = 3'd6
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_WAIT_MAX = 8;
    localparam int DEF_GAP      = 0;
    localparam int CNT_W        = 4;
    localparam int GAP_W        = 8;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter: picks the first set request at or after
// the pointer (modulo N) and returns it one-hot together with a found flag.
module uart_rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          found
);

    logic [N-1:0]  rot_req;
    logic [IW-1:0] rot_idx [N];
    logic [IW-1:0] sel;

    // Slot gi of the rotated view is requester (ptr + gi) mod N.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IW:0] rot_sum;
        assign rot_sum      = {1'b0, ptr} + (IW+1)'(gi);
        assign rot_idx[gi]  = (rot_sum >= (IW+1)'(N)) ? IW'(rot_sum - (IW+1)'(N))
                                                     : IW'(rot_sum);
        assign rot_req[gi]  = req[rot_idx[gi]];
    end

    // Walking downwards lets the lowest rotated slot win.
    always_comb begin
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                sel = rot_idx[k];
            end
        end
    end

    assign found = |req;

    for (genvar gi = 0; gi < N; gi++) begin : g_win
        assign winner[gi] = found && (sel == IW'(gi));
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N requesters with round-robin
// arbitration; the winner keeps the grant until it sends a byte marked last.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int WAIT_MAX = DEF_WAIT_MAX,
    parameter int GAP      = DEF_GAP
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   ack,
    output logic           err,
    output logic [N-1:0]   grant,
    input  logic           tx_ready,
    output logic           tx_send,
    output logic [7:0]     tx_data
);

    localparam int              IW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t             state_reg,   state_next;
    logic [N-1:0]       grant_reg,   grant_next;
    logic               lock_reg,    lock_next;
    logic [IW-1:0]      rr_ptr_reg,  rr_ptr_next;
    logic [IW-1:0]      owner_reg,   owner_next;
    logic               tx_send_reg, tx_send_next;
    logic [7:0]         tx_data_reg, tx_data_next;
    logic               last_reg,    last_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [GAP_W-1:0]   gap_reg,     gap_next;
    logic [N-1:0]       ack_reg,     ack_next;
    logic               err_reg,     err_next;

    logic [N-1:0]       arb_winner;
    logic               arb_found;
    logic [IW-1:0]      arb_idx;

    uart_rr_arb #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr_reg),
        .winner (arb_winner),
        .found  (arb_found)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_winner[i]) begin
                arb_idx = arb_idx | IW'(i);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        lock_next    = lock_reg;
        rr_ptr_next  = rr_ptr_reg;
        owner_next   = owner_reg;
        tx_send_next = tx_send_reg;
        tx_data_next = tx_data_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        gap_next     = gap_reg;
        ack_next     = '0;
        err_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (!lock_reg) begin
                    if (arb_found && tx_ready) begin
                        grant_next = arb_winner;
                        owner_next = arb_idx;
                        lock_next  = 1'b1;
                        state_next = S_LOAD;
                    end
                end else if (req[owner_reg] && tx_ready) begin
                    // Locked: only the owner may continue its frame.
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_next = req_data[{owner_reg, 3'b000} +: 8];
                last_next    = req_last[owner_reg];
                state_next   = S_SEND;
            end
            S_SEND: begin
                tx_send_next = 1'b1;
                cnt_next     = '0;
                state_next   = S_WAITBUSY;
            end
            S_WAITBUSY: begin
                if (!tx_ready) begin
                    tx_send_next = 1'b0;
                    state_next   = S_WAITDONE;
                end else if (cnt_reg == WAIT_LAST) begin
                    // Transmitter never accepted the strobe: abort the byte.
                    tx_send_next = 1'b0;
                    ack_next     = grant_reg;
                    err_next     = 1'b1;
                    state_next   = S_RELEASE;
                end else if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WAITDONE: begin
                if (tx_ready) begin
                    ack_next   = grant_reg;
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (last_reg || err_reg) begin
                    lock_next   = 1'b0;
                    grant_next  = '0;
                    rr_ptr_next = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + 1'b1;
                end
                if (GAP > 0) begin
                    gap_next   = '0;
                    state_next = S_GAP;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= S_IDLE;
            grant_reg   <= '0;
            lock_reg    <= 1'b0;
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            tx_send_reg <= 1'b0;
            tx_data_reg <= '0;
            last_reg    <= 1'b0;
            cnt_reg     <= '0;
            gap_reg     <= '0;
            ack_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            lock_reg    <= lock_next;
            rr_ptr_reg  <= rr_ptr_next;
            owner_reg   <= owner_next;
            tx_send_reg <= tx_send_next;
            tx_data_reg <= tx_data_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            gap_reg     <= gap_next;
            ack_reg     <= ack_next;
            err_reg     <= err_next;
        end
    end

    assign ack     = ack_reg;
    assign err     = err_reg;
    assign grant   = grant_reg;
    assign tx_send = tx_send_reg;
    assign tx_data = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester drivers, a transmitter model
// that checks each strobed byte, and an ack monitor checking owner and err.
module tb_uart_tx_sched;

    logic        Clock;
    logic        Reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic        err;
    logic [3:0]  grant;
    logic        tx_ready;
    logic        tx_send;
    logic [7:0]  tx_data;

    int n_vec = 0;
    int n_err = 0;
    int busy_len = 4;
    bit stuck = 1'b0;

    logic [7:0] exp_tx[$];
    int         exp_ack_idx[$];
    int         exp_ack_err[$];

    logic [8:0] rq_mem [4][16];
    int         rq_head [4];
    int         rq_tail [4];

    uart_tx_sched #(
        .N        (4),
        .WAIT_MAX (8),
        .GAP      (0)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .err      (err),
        .grant    (grant),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_data  (tx_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Queue a byte for requester r and record its expected transmission/ack.
    task automatic push_byte(input int r, input logic [7:0] d, input logic l, input int e);
        rq_mem[r][rq_tail[r]] = {l, d};
        rq_tail[r]++;
        exp_tx.push_back(d);
        exp_ack_idx.push_back(r);
        exp_ack_err.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        exp_tx.delete();
        exp_ack_idx.delete();
        exp_ack_err.delete();
        repeat (2) @(negedge Clock);
        check("rst_ack",     32'(ack),     32'h0);
        check("rst_err",     32'(err),     32'h0);
        check("rst_grant",   32'(grant),   32'h0);
        check("rst_tx_send", 32'(tx_send), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        Reset = 1'b1;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_tx.size() != 0 || exp_ack_idx.size() != 0) && t < 600) begin
            @(negedge Clock);
            t++;
        end
        n_vec++;
        if (t >= 600) begin
            n_err++;
            $display("FAIL %s_drain: pending tx=%0d ack=%0d, expected 0/0",
                     name, exp_tx.size(), exp_ack_idx.size());
        end
    endtask

    // Requester drivers: hold req with the queue head, advance on ack.
    initial begin
        req = '0;
        req_data = '0;
        req_last = '0;
        forever begin
            @(posedge Clock);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (Reset && ack[i] && rq_head[i] < rq_tail[i]) rq_head[i]++;
                if (rq_head[i] < rq_tail[i]) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
                    req_last[i] = rq_mem[i][rq_head[i]][8];
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
    end

    // Transmitter model: accepts on a rising tx_send, busy for busy_len clocks.
    initial begin
        logic       prev;
        int         busy;
        logic [7:0] d;
        tx_ready = 1'b1;
        prev = 1'b0;
        busy = 0;
        forever begin
            @(posedge Clock);
            #1;
            if (!Reset) begin
                tx_ready = 1'b1;
                busy = 0;
                prev = 1'b0;
            end else begin
                if (tx_send && !prev) begin
                    if (exp_tx.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL tx_unexpected: got byte %0h, expected none", tx_data);
                    end else begin
                        d = exp_tx.pop_front();
                        check("tx_data", 32'(tx_data), 32'(d));
                    end
                    if (!stuck) begin
                        tx_ready = 1'b0;
                        busy = busy_len - 1;
                    end
                end else if (!tx_ready) begin
                    if (busy > 0) busy--;
                    else tx_ready = 1'b1;
                end
                prev = tx_send;
            end
        end
    end

    // Ack monitor: pops the scoreboard whenever ack or err is presented.
    initial begin
        int ei, ee;
        forever begin
            @(negedge Clock);
            if (Reset && (ack != 4'h0 || err)) begin
                if (exp_ack_idx.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ack_unexpected: got ack=%b err=%b, expected none", ack, err);
                end else begin
                    ei = exp_ack_idx.pop_front();
                    ee = exp_ack_err.pop_front();
                    $display("ack: requester %0d err=%0d ack=%b grant=%b", ei, err, ack, grant);
                    check("ack_vec",     32'(ack),     32'(1 << ei));
                    check("ack_err",     32'(err),     32'(ee));
                    check("ack_owner",   32'(grant),   32'(1 << ei));
                    check("ack_sendlow", 32'(tx_send), 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int hi, rises, t;
        logic p;
        Reset = 1'b0;
        stuck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end

        // Single byte with latency check.
        do_reset();
        busy_len = 10;
        push_byte(0, 8'h41, 1'b1, 0);
        @(negedge Clock);
        check("t1_grant_before", 32'(grant), 32'h0);
        @(negedge Clock);
        check("t1_grant_won", 32'(grant), 32'h1);
        @(negedge Clock);
        check("t1_send_clk2", 32'(tx_send), 32'h0);
        @(negedge Clock);
        check("t1_send_clk3", 32'(tx_send), 32'h1);
        check("t1_tx_data", 32'(tx_data), 32'h41);
        drain("t1");
        @(negedge Clock);
        check("t1_grant_released", 32'(grant), 32'h0);

        // Fairness: all four requesters held for two bytes each.
        do_reset();
        busy_len = 3;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 4; r++)
                push_byte(r, 8'(8'h20 + b * 4 + r), 1'b1, 0);
        drain("t2");
        @(negedge Clock);
        check("t2_grant_released", 32'(grant), 32'h0);

        // Frame lock: three-byte frame from 1 while 2 waits.
        do_reset();
        busy_len = 2;
        push_byte(1, 8'hA1, 1'b0, 0);
        push_byte(1, 8'hA2, 1'b0, 0);
        push_byte(1, 8'hA3, 1'b1, 0);
        push_byte(2, 8'hB1, 1'b1, 0);
        drain("t3");

        // Timeout: transmitter never goes busy; lock released despite last=0.
        do_reset();
        stuck = 1'b1;
        push_byte(2, 8'h5A, 1'b0, 1);
        hi = 0;
        t = 0;
        while (exp_ack_idx.size() != 0 && t < 100) begin
            @(negedge Clock);
            if (tx_send) hi++;
            t++;
        end
        check("t4_send_high_cycles", 32'(hi), 32'd8);
        @(negedge Clock);
        check("t4_grant_released", 32'(grant), 32'h0);
        stuck = 1'b0;
        push_byte(1, 8'h11, 1'b1, 0);
        drain("t4");

        // Reset during WAITDONE aborts the byte without an ack.
        do_reset();
        busy_len = 10;
        push_byte(0, 8'h77, 1'b1, 0);
        t = 0;
        while (!(tx_send == 1'b0 && tx_ready == 1'b0 && grant != 4'h0) && t < 50) begin
            @(negedge Clock);
            t++;
        end
        check("t5_reached_waitdone", 32'(t < 50), 32'h1);
        Reset = 1'b0;
        #1;
        check("t5_ack_now",   32'(ack),     32'h0);
        check("t5_grant_now", 32'(grant),   32'h0);
        check("t5_send_now",  32'(tx_send), 32'h0);
        check("t5_byte_seen", 32'(exp_tx.size()), 32'h0);
        do_reset();
        busy_len = 3;
        push_byte(3, 8'h3C, 1'b1, 0);
        drain("t5");

        // Back-to-back bytes from one owner need separate strobes.
        do_reset();
        busy_len = 2;
        push_byte(3, 8'hC3, 1'b0, 0);
        push_byte(3, 8'hC4, 1'b1, 0);
        rises = 0;
        p = 1'b0;
        t = 0;
        while ((exp_tx.size() != 0 || exp_ack_idx.size() != 0) && t < 200) begin
            @(negedge Clock);
            if (tx_send && !p) rises++;
            p = tx_send;
            t++;
        end
        check("t6_send_rises", 32'(rises), 32'd2);
        drain("t6");

        repeat (3) @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
